// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: the hazard
// FSM state encoding, the hard-wired zero register index and the bound on
// the instruction-memory read latency the redirect logic can cover.
package cpu_ctrl_pkg;

    // Controller states: IDLE before the first run, RUN for normal
    // sequencing, REDIR while IF/ID is still being flushed after a redirect
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } hazard_state_e;

    // $zero never carries a real dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Largest supported instruction-memory read latency
    localparam int IMEM_LAT_MAX = 3;

    // Width of the redirect down-counter, sized for IMEM_LAT_MAX
    localparam int LAT_W = $clog2(IMEM_LAT_MAX + 1);

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Clear wins over increment; the count sticks at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] MAX_COUNT = '1;

    logic [WIDTH-1:0] r_count;

    // Count register: reset/clear to zero, otherwise saturating increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_COUNT)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Produces the
// per-stage enable and flush strobes, inserts a one-cycle bubble on a
// load-use dependency, flushes three stages on a branch/jump resolved in
// MEM, and keeps IF/ID flushed for IMEM_LAT more cycles so the stale
// synchronous I-mem read never reaches decode.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int IMEM_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_waddr,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_jump,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(IMEM_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

    hazard_state_e    r_state;
    hazard_state_e    w_nextState;
    logic [LAT_W-1:0] r_redirCnt;
    logic [LAT_W-1:0] w_nextRedirCnt;

    logic             w_redirect;
    logic             w_loadUse;

    logic             w_pcEn;
    logic             w_ifidEn;
    logic             w_ifidFlush;
    logic             w_idexEn;
    logic             w_idexFlush;
    logic             w_exmemFlush;
    logic             w_stallInc;
    logic             w_flushInc;

    logic [CNT_W-1:0] w_stallCount;
    logic [CNT_W-1:0] w_flushCount;

    // A taken branch or any jump resolved in MEM redirects the fetch stream
    assign w_redirect = mem_jump | (mem_branch & mem_zero);

    // A load in EX feeding a source register of the ID instruction; rt only
    // counts when the instruction actually reads it, and $zero never does
    assign w_loadUse = ex_mem_read
                     & (ex_waddr != REG_ZERO)
                     & ((ex_waddr == id_rs) | (id_uses_rt & (ex_waddr == id_rt)));

    // State and redirect-counter registers; enable=0 holds both via next-state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_redirCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_redirCnt <= w_nextRedirCnt;
        end
    end

    // Next-state and strobe decode; redirect outranks load-use because the
    // instructions that would stall are on the wrong path anyway
    always_comb begin
        w_nextState    = r_state;
        w_nextRedirCnt = r_redirCnt;
        w_pcEn         = 1'b0;
        w_ifidEn       = 1'b0;
        w_ifidFlush    = 1'b0;
        w_idexEn       = 1'b0;
        w_idexFlush    = 1'b0;
        w_exmemFlush   = 1'b0;
        w_stallInc     = 1'b0;
        w_flushInc     = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_nextState = RUN;
                end
            end

            RUN: begin
                if (enable) begin
                    w_pcEn   = 1'b1;
                    w_ifidEn = 1'b1;
                    w_idexEn = 1'b1;
                    if (w_redirect) begin
                        w_ifidFlush  = 1'b1;
                        w_idexFlush  = 1'b1;
                        w_exmemFlush = 1'b1;
                        w_flushInc   = 1'b1;
                        if (IMEM_LAT > 0) begin
                            w_nextState    = REDIR;
                            w_nextRedirCnt = LAT_LOAD;
                        end
                    end else if (w_loadUse) begin
                        w_pcEn      = 1'b0;
                        w_ifidEn    = 1'b0;
                        w_idexFlush = 1'b1;
                        w_stallInc  = 1'b1;
                    end
                end
            end

            REDIR: begin
                if (enable) begin
                    w_pcEn      = 1'b1;
                    w_ifidEn    = 1'b1;
                    w_idexEn    = 1'b1;
                    w_ifidFlush = 1'b1;
                    if (w_redirect) begin
                        w_idexFlush    = 1'b1;
                        w_exmemFlush   = 1'b1;
                        w_flushInc     = 1'b1;
                        w_nextRedirCnt = LAT_LOAD;
                    end else begin
                        w_nextRedirCnt = r_redirCnt - LAT_ONE;
                        if (r_redirCnt <= LAT_ONE) begin
                            w_nextState = RUN;
                        end
                    end
                end
            end

            default: begin
                w_nextState    = IDLE;
                w_nextRedirCnt = '0;
            end
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stallCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stallInc),
        .i_clr   (clr_cnt),
        .o_count (w_stallCount)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flushCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_flushInc),
        .i_clr   (clr_cnt),
        .o_count (w_flushCount)
    );

    // Every output reads zero while reset is asserted, even before the edge
    assign pc_en       = w_pcEn       & ~rst;
    assign ifid_en     = w_ifidEn     & ~rst;
    assign ifid_flush  = w_ifidFlush  & ~rst;
    assign idex_en     = w_idexEn     & ~rst;
    assign idex_flush  = w_idexFlush  & ~rst;
    assign exmem_flush = w_exmemFlush & ~rst;
    assign stall_cnt   = rst ? '0 : w_stallCount;
    assign flush_cnt   = rst ? '0 : w_flushCount;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Generates per-stage enable and flush strobes for the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards (1-cycle bubble) and redirects on branch/jump resolved in MEM (3-stage flush).
- Covers synchronous instruction-memory read latency with an extended IF/ID flush; keeps saturating stall/flush performance counters.

Parameters:
- IMEM_LAT, 1, extra cycles IF/ID stays flushed after a redirect (0..3; equals I-mem read latency).
- CNT_W, 16, width of the performance counters.

Ports:
- clk, input, 1, core clock.
- rst, input, 1, synchronous reset, active-high.
- enable, input, 1, global run; low freezes the pipeline.
- id_rs, input, 5, ID-stage source register rs (instruction[25:21]).
- id_rt, input, 5, ID-stage source register rt (instruction[20:16]).
- id_uses_rt, input, 1, ID instruction reads rt (R-type, beq, sw).
- ex_mem_read, input, 1, EX-stage instruction is a load.
- ex_waddr, input, 5, EX-stage destination register.
- mem_branch, input, 1, MEM-stage branch flag.
- mem_zero, input, 1, MEM-stage ALU zero flag.
- mem_jump, input, 1, MEM-stage jump flag.
- clr_cnt, input, 1, synchronous clear of both counters.
- pc_en, output, 1, PC update enable.
- ifid_en, output, 1, IF/ID load enable.
- ifid_flush, output, 1, IF/ID loads zero (nop) when enabled.
- idex_en, output, 1, ID/EX load enable.
- idex_flush, output, 1, ID/EX loads zero (bubble) when enabled.
- exmem_flush, output, 1, EX/MEM loads zero when enabled.
- stall_cnt, output, CNT_W, load-use stall cycles, saturating.
- flush_cnt, output, CNT_W, redirect events, saturating.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset state: state=IDLE, redirect counter=0, both performance counters=0.
- While rst=1, all outputs are 0.
- Derived signals:
  - redirect = mem_jump | (mem_branch & mem_zero).
  - load_use = ex_mem_read & (ex_waddr != 0) & ((ex_waddr == id_rs) | (id_uses_rt & ex_waddr == id_rt)).
  - Both are combinational. Stall and flush strobes act in the same cycle they are detected (zero latency).
- States: IDLE, RUN, REDIR. Encoding lives in the package.
- IDLE: all enables 0, all flushes 0. Go to RUN on enable=1.
- RUN, enable=1:
  - Default: pc_en, ifid_en and idex_en are 1; all flushes 0.
  - If load_use & !redirect: pc_en=0, ifid_en=0, idex_flush=1, stall_cnt+1.
  - If redirect: pc_en=1, ifid_flush=1, idex_flush=1, exmem_flush=1, flush_cnt+1.
    - With IMEM_LAT>0: load counter with IMEM_LAT and go to REDIR.
    - With IMEM_LAT=0: stay in RUN.
- REDIR, enable=1:
  - Enables as in RUN; ifid_flush=1.
  - Counter decrements; go to RUN when it reaches 1.
  - load_use is ignored (ID holds a nop).
  - A redirect in REDIR applies the full flush, reloads the counter with IMEM_LAT and increments flush_cnt.
- enable=0 in any state:
  - All enables and flushes are 0.
  - State, counter and perf counters hold.
  - RUN and REDIR resume where they left off once enable returns to 1.
  - RUN goes to IDLE only on rst.
- Simultaneous load_use and redirect: redirect wins. The stalled instructions are wrong-path, and stall_cnt does not increment.
- A load-use stall lasts exactly one cycle. The next cycle, EX holds the bubble, so ex_mem_read=0.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clr_cnt has priority over increment in the same cycle.
  - Increments occur only when enable=1.
- ex_waddr=0 never causes a stall ($zero is not a real dependency).

Decomposition:
- Package cpu_ctrl_pkg:
  - hazard-state enum {IDLE, RUN, REDIR}.
  - REG_ZERO=5'd0.
  - IMEM_LAT upper bound constant (3).
- Sub-module sat_counter (width parameter; inc, clr, sync rst), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset, then enable=1 with no hazards -> pc_en=ifid_en=idex_en=1 and all flushes 0 from the first RUN cycle; stall_cnt=flush_cnt=0.
- lw $2 in EX (ex_mem_read=1, ex_waddr=2) with add $3,$2,$1 in ID (id_rs=2) -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Same case with ex_waddr=0 -> no stall.
- Hazard on rt only: id_rt=5, ex_waddr=5 -> stall when id_uses_rt=1, no stall when id_uses_rt=0.
- Taken beq (mem_branch=1, mem_zero=1) with IMEM_LAT=1 -> cycle 0 raises ifid/idex/exmem flush, cycle 1 raises ifid_flush only, cycle 2 is back to normal; flush_cnt=1. Not-taken (mem_zero=0) -> no flush.
- Same-cycle mem_jump=1 and load_use=1 -> full flush, pc_en=1, stall_cnt unchanged, flush_cnt+1.
- enable dropped while in REDIR, then raised 3 cycles later -> outputs 0 while low, remaining ifid_flush cycle delivered after resume. rst pulse mid-stall -> all outputs 0 and counters 0 the next cycle. Counter driven to 0xFFFF -> holds at 0xFFFF; clr_cnt together with an increment -> 0.
